// File: rtl/signed_calc_seq_if.sv
// Operand/result handshake bundle for signed_calc_seq.
// The slave modport is the calculator's view; master is the producer/consumer side.
interface signed_calc_seq_if #(
  parameter int W_IN  = 5,
  parameter int W_OUT = W_IN + 5
);
  logic              i_valid;
  logic              o_ready;
  logic [W_IN-1:0]   i_as;
  logic [W_IN-1:0]   i_bs;
  logic              i_abort;
  logic              o_valid;
  logic              i_ready;
  logic [W_OUT-1:0]  o_fs;
  logic              o_busy;

  modport slave (
    input  i_valid, i_as, i_bs, i_abort, i_ready,
    output o_ready, o_valid, o_fs, o_busy
  );

  modport master (
    output i_valid, i_as, i_bs, i_abort, i_ready,
    input  o_ready, o_valid, o_fs, o_busy
  );
endinterface

// File: rtl/signed_calc_seq.sv
// Sequenced evaluator of F = CA*A - CB*B using one shared add/subtract unit.
// Four MUL_A cycles then four MUL_B cycles, one coefficient bit per cycle,
// then the result is held in DONE until the consumer takes it.
module signed_calc_seq #(
  parameter int         W_IN  = 5,
  parameter logic [3:0] CA    = 4'd6,
  parameter logic [3:0] CB    = 4'd11,
  parameter int         W_OUT = W_IN + 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  signed_calc_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL_A = 2'd1,
    S_MUL_B = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [W_OUT-1:0]   acc_q, acc_d;
  logic signed [W_OUT-1:0]   a_q, a_d;
  logic signed [W_OUT-1:0]   b_q, b_d;
  logic signed [W_OUT-1:0]   fs_q, fs_d;
  logic [1:0]                idx_q, idx_d;

  // Shared datapath signals
  logic                      coef_bit_s;
  logic signed [W_OUT-1:0]   shifted_s;
  logic signed [W_OUT-1:0]   addsub_s;

  // Shared add/subtract unit: adds shifted A in MUL_A, subtracts shifted B otherwise
  always_comb begin
    coef_bit_s = 1'b0;
    shifted_s  = '0;
    addsub_s   = acc_q;
    if (state_q == S_MUL_A) begin
      coef_bit_s = CA[idx_q];
      shifted_s  = a_q <<< idx_q;
      addsub_s   = acc_q + shifted_s;
    end else begin
      coef_bit_s = CB[idx_q];
      shifted_s  = b_q <<< idx_q;
      addsub_s   = acc_q - shifted_s;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    fs_d    = fs_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          a_d     = {{(W_OUT-W_IN){bus.i_as[W_IN-1]}}, bus.i_as};
          b_d     = {{(W_OUT-W_IN){bus.i_bs[W_IN-1]}}, bus.i_bs};
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = S_MUL_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_A, S_MUL_B: begin
        if (bus.i_abort) begin
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          if (coef_bit_s) begin
            acc_d = addsub_s;
          end else begin
            acc_d = acc_q;
          end
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (state_q == S_MUL_A) begin
              state_d = S_MUL_B;
            end else begin
              // Capture the final sum so o_fs is stable for the whole DONE stay
              fs_d    = acc_d;
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        if (bus.i_abort) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (bus.i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fs_q    <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fs_q    <= fs_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = (state_q == S_DONE);
  assign bus.o_busy  = (state_q != S_IDLE);
  assign bus.o_fs    = fs_q;

endmodule

// File: tb/tb_signed_calc_seq.sv
// Self-checking bench for signed_calc_seq: vector table, scoreboard queue,
// and hand-written sequences for backpressure, abort, async reset and overrides.
module tb_signed_calc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_calc_seq_if #(.W_IN(5), .W_OUT(10)) ifc ();
  signed_calc_seq_if #(.W_IN(5), .W_OUT(10)) ifc2 ();

  signed_calc_seq #(.W_IN(5), .CA(4'd6), .CB(4'd11), .W_OUT(10)) dut (
    .i_clk(clk), .i_rst(rst), .bus(ifc.slave)
  );

  signed_calc_seq #(.W_IN(5), .CA(4'd15), .CB(4'd0), .W_OUT(10)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(ifc2.slave)
  );

  typedef struct {
    int a;
    int b;
    int exp;
    int bp;
  } vec_t;

  vec_t vecs[7];
  logic signed [31:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Count cycles (accept cycle = 0) until o_valid; flag o_ready/o_busy errors.
  task automatic wait_valid(output int cyc, output logic bad);
    cyc = 1;
    bad = 1'b0;
    while (ifc.o_valid !== 1'b1 && cyc < 30) begin
      if (ifc.o_ready !== 1'b0 || ifc.o_busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (ifc.o_ready !== 1'b0 || ifc.o_busy !== 1'b1) bad = 1'b1;
  endtask

  // Present an operand pair at a negedge; returns at the negedge after accept.
  task automatic start(input int a, input int b, input logic rdy);
    ifc.i_as    = a[4:0];
    ifc.i_bs    = b[4:0];
    ifc.i_valid = 1'b1;
    ifc.i_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    ifc.i_valid = 1'b0;
  endtask

  task automatic do_txn(input int a, input int b, input int exp, input int bp);
    int cyc;
    logic bad;
    logic [9:0] fs_hold;
    logic signed [31:0] sb_exp;
    check("idle_ready", ifc.o_ready, 1);
    sb_q.push_back(exp);
    start(a, b, (bp == 0));
    wait_valid(cyc, bad);
    check("latency", cyc, 9);
    check("ready_low_busy_high", bad, 0);
    fs_hold = ifc.o_fs;
    for (int k = 0; k < bp; k++) begin
      ifc.i_valid = 1'b1;
      ifc.i_as    = 5'd3;
      ifc.i_bs    = 5'd3;
      @(negedge clk);
      check("bp_valid", ifc.o_valid, 1);
      check("bp_fs_stable", ifc.o_fs, fs_hold);
      check("bp_ready", ifc.o_ready, 0);
    end
    ifc.i_valid = 1'b0;
    ifc.i_ready = 1'b1;
    if (sb_q.size() > 0) sb_exp = sb_q.pop_front();
    else sb_exp = 32'sd99999;
    check($sformatf("result_a%0d_b%0d", a, b), $signed(ifc.o_fs), sb_exp);
    @(negedge clk);
    check("ready_after_hs", ifc.o_ready, 1);
    check("valid_drop", ifc.o_valid, 0);
    ifc.i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic bad;
    logic seen;
    int ra, rb;
    logic signed [31:0] e2;

    vecs[0] = '{a:  3, b:   2, exp:   -4, bp: 0};
    vecs[1] = '{a: -16, b: 15, exp: -261, bp: 0};
    vecs[2] = '{a:  15, b: -16, exp: 266, bp: 0};
    vecs[3] = '{a: -16, b: -16, exp:  80, bp: 0};
    vecs[4] = '{a:  7, b:   1, exp:   31, bp: 5};
    vecs[5] = '{a:  0, b: -1, exp:   11, bp: 0};
    vecs[6] = '{a: -1, b:  0, exp:   -6, bp: 2};

    ifc.i_valid = 1'b0; ifc.i_as = '0; ifc.i_bs = '0; ifc.i_abort = 1'b0; ifc.i_ready = 1'b0;
    ifc2.i_valid = 1'b0; ifc2.i_as = '0; ifc2.i_bs = '0; ifc2.i_abort = 1'b0; ifc2.i_ready = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_ready", ifc.o_ready, 1);
    check("rst_valid", ifc.o_valid, 0);
    check("rst_busy", ifc.o_busy, 0);
    check("rst_fs", ifc.o_fs, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors (back-to-back in the first IDLE cycle)
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].bp);
    end

    // Random operands checked against the bench's own equation
    for (int i = 0; i < 4; i++) begin
      ra = int'($urandom_range(0, 31)) - 16;
      rb = int'($urandom_range(0, 31)) - 16;
      do_txn(ra, rb, 6 * ra - 11 * rb, i);
    end

    // Abort in MUL_B with idx=1 (cycle 6 after accept)
    start(5, 3, 1'b1);
    repeat (5) @(negedge clk);
    ifc.i_abort = 1'b1;
    @(negedge clk);
    ifc.i_abort = 1'b0;
    check("abort_busy", ifc.o_busy, 0);
    check("abort_ready", ifc.o_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.o_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    ifc.i_ready = 1'b0;
    do_txn(1, 1, -5, 0);

    // Abort while holding a result in DONE
    start(2, 1, 1'b0);
    wait_valid(cyc, bad);
    check("done_abort_latency", cyc, 9);
    ifc.i_abort = 1'b1;
    @(negedge clk);
    ifc.i_abort = 1'b0;
    check("done_abort_valid", ifc.o_valid, 0);
    check("done_abort_ready", ifc.o_ready, 1);

    // Asynchronous reset in the middle of MUL_A
    start(9, 2, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", ifc.o_ready, 1);
    check("arst_busy", ifc.o_busy, 0);
    check("arst_valid", ifc.o_valid, 0);
    check("arst_fs", ifc.o_fs, 0);
    @(negedge clk);
    rst = 1'b0;
    ifc.i_ready = 1'b0;
    @(negedge clk);
    do_txn(0, 0, 0, 0);

    // Coefficient override instance: CA=15, CB=0
    ifc2.i_as = 5'b10000;
    ifc2.i_bs = 5'd5;
    ifc2.i_valid = 1'b1;
    ifc2.i_ready = 1'b1;
    sb_q.push_back(-240);
    @(posedge clk);
    @(negedge clk);
    ifc2.i_valid = 1'b0;
    cyc = 1;
    while (ifc2.o_valid !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("ovr_latency", cyc, 9);
    if (sb_q.size() > 0) e2 = sb_q.pop_front();
    else e2 = 32'sd99999;
    check("ovr_result", $signed(ifc2.o_fs), e2);
    @(negedge clk);
    check("ovr_ready_after", ifc2.o_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
